// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between two pipeline stages.
// The stage itself uses the slave view; the upstream/downstream side uses master.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main entry plus one-entry skid buffer.
// in_ready comes straight from the occupancy state, so no combinational path
// runs from out_ready back to in_ready. out_ctrl is masked to CTRL_NOP on bubbles.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [CNT_W-1:0]  stall_q;

    logic main_valid;
    logic acc, take;
    logic main_load_in, main_load_skid, skid_load;

    assign main_valid = (state_q != StEmpty);
    assign bus.in_ready  = (state_q != StFull);
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_ctrl  = main_valid ? main_ctrl_q : CTRL_NOP;
    assign stall_count   = stall_q;

    assign acc  = bus.in_valid & bus.in_ready & ~flush;
    assign take = main_valid & bus.out_ready;

    // Next occupancy and which entries load this cycle.
    always_comb begin
        state_d        = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    main_load_in = 1'b1;
                    state_d      = StOne;
                end
            end
            StOne: begin
                if (acc && take) begin
                    main_load_in = 1'b1;
                end else if (acc) begin
                    skid_load = 1'b1;
                    state_d   = StFull;
                end else if (take) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // Skid moves up only when not flushing; on flush its contents are dead anyway.
                if (take && !flush) begin
                    main_load_skid = 1'b1;
                    state_d        = StOne;
                end else if (take) begin
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; they hold their value while their entry is invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_data_q <= '0;
            main_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (main_load_in) begin
                main_data_q <= bus.in_data;
                main_ctrl_q <= bus.in_ctrl;
            end else if (main_load_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (skid_load) begin
                skid_data_q <= bus.in_data;
                skid_ctrl_q <= bus.in_ctrl;
            end
        end
    end

    // Saturating count of stalled output cycles; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (main_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand-written corner sequences
// and random traffic against a queue-based model. Two instances share stimulus:
// one with the default 16-bit stall counter, one with a 4-bit counter.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;
    logic [15:0] stall16;
    logic [3:0]  stall4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) bus16 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) bus4 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.in_data   = in_data;
    assign bus16.in_ctrl   = in_ctrl;
    assign bus16.out_ready = out_ready;
    assign bus4.in_valid   = in_valid;
    assign bus4.in_data    = in_data;
    assign bus4.in_ctrl    = in_ctrl;
    assign bus4.out_ready  = out_ready;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_NOP(16'h0000), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .bus         (bus16),
        .stall_count (stall16)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_NOP(16'h0000), .CNT_W(4)) dut_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .bus         (bus4),
        .stall_count (stall4)
    );

    // Reference model: a FIFO of at most two beats plus an unbounded stall tally.
    typedef struct packed {
        logic [31:0] d;
        logic [15:0] c;
    } beat_t;
    beat_t mq[$];
    int    mcnt;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [15:0] c;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_data;
        logic [15:0] e_ctrl;
        int          e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit tk, ac;
        tk = (mq.size() > 0) && out_ready;
        ac = in_valid && (mq.size() < 2) && !flush;
        if ((mq.size() > 0) && !out_ready) mcnt++;
        if (tk) void'(mq.pop_front());
        if (ac) mq.push_back('{d: in_data, c: in_ctrl});
        if (flush) mq.delete();
    endtask

    task automatic cycle(input logic iv, input logic [31:0] d, input logic [15:0] c,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [15:0] ec;
        ec = (mq.size() > 0) ? mq[0].c : 16'h0000;
        chk({tag, " out_valid"}, 32'(bus16.out_valid), 32'(mq.size() > 0));
        chk({tag, " in_ready"}, 32'(bus16.in_ready), 32'(mq.size() < 2));
        chk({tag, " out_ctrl"}, 32'(bus16.out_ctrl), 32'(ec));
        if (mq.size() > 0) chk({tag, " out_data"}, bus16.out_data, mq[0].d);
        chk({tag, " stall16"}, 32'(stall16), 32'((mcnt > 65535) ? 65535 : mcnt));
        chk({tag, " sat out_valid"}, 32'(bus4.out_valid), 32'(mq.size() > 0));
        chk({tag, " stall4"}, 32'(stall4), 32'((mcnt > 15) ? 15 : mcnt));
    endtask

    initial begin
        vec_t vt[$];
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        mcnt      = 0;

        // Reset values, before any clock edge.
        #2;
        chk("rst out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus16.in_ready), 32'd1);
        chk("rst out_data", bus16.out_data, 32'd0);
        chk("rst out_ctrl", 32'(bus16.out_ctrl), 32'd0);
        chk("rst stall", 32'(stall16), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // iv, data, ctrl, out_ready, flush -> valid, ready, data, ctrl, stall_count
        vt.push_back('{1, 32'h100, 16'h0011, 1, 0, 1, 1, 32'h100, 16'h0011, 0}); // stream
        vt.push_back('{1, 32'h104, 16'h0012, 1, 0, 1, 1, 32'h104, 16'h0012, 0});
        vt.push_back('{1, 32'h108, 16'h0013, 1, 0, 1, 1, 32'h108, 16'h0013, 0});
        vt.push_back('{0, 32'h0,   16'h0,    1, 0, 0, 1, 32'h108, 16'h0000, 0});
        vt.push_back('{1, 32'hA,   16'h00A0, 1, 0, 1, 1, 32'hA,   16'h00A0, 0}); // skid
        vt.push_back('{1, 32'hB,   16'h00B0, 0, 0, 1, 0, 32'hA,   16'h00A0, 1});
        vt.push_back('{1, 32'hC,   16'h00C0, 0, 0, 1, 0, 32'hA,   16'h00A0, 2});
        vt.push_back('{1, 32'hC,   16'h00C0, 0, 0, 1, 0, 32'hA,   16'h00A0, 3});
        vt.push_back('{1, 32'hC,   16'h00C0, 1, 0, 1, 1, 32'hB,   16'h00B0, 3});
        vt.push_back('{1, 32'hC,   16'h00C0, 1, 0, 1, 1, 32'hC,   16'h00C0, 3});
        vt.push_back('{0, 32'h0,   16'h0,    1, 0, 0, 1, 32'hC,   16'h0000, 3});
        vt.push_back('{1, 32'h1,   16'h0101, 0, 0, 1, 1, 32'h1,   16'h0101, 3}); // flush
        vt.push_back('{1, 32'h2,   16'h0202, 0, 0, 1, 0, 32'h1,   16'h0101, 4});
        vt.push_back('{1, 32'h3,   16'h0303, 0, 1, 0, 1, 32'h1,   16'h0000, 5});
        vt.push_back('{0, 32'h0,   16'h0,    1, 0, 0, 1, 32'h1,   16'h0000, 5});
        vt.push_back('{1, 32'h55,  16'hFFFF, 1, 0, 1, 1, 32'h55,  16'hFFFF, 5}); // mask
        vt.push_back('{0, 32'h0,   16'h0,    1, 0, 0, 1, 32'h55,  16'h0000, 5});
        vt.push_back('{0, 32'h0,   16'h0,    0, 0, 0, 1, 32'h55,  16'h0000, 5});

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].iv, vt[i].d, vt[i].c, vt[i].ordy, vt[i].fl);
            chk($sformatf("vec%0d out_valid", i), 32'(bus16.out_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d in_ready", i), 32'(bus16.in_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d out_data", i), bus16.out_data, vt[i].e_data);
            chk($sformatf("vec%0d out_ctrl", i), 32'(bus16.out_ctrl), 32'(vt[i].e_ctrl));
            chk($sformatf("vec%0d stall", i), 32'(stall16), 32'(vt[i].e_cnt));
        end
        check_model("post-table");

        // Asynchronous reset with the stage full and stalled.
        cycle(1, 32'h77, 16'h0707, 0, 0);
        cycle(1, 32'h78, 16'h0808, 0, 0);
        cycle(0, 32'h0, 16'h0, 0, 0);
        check_model("pre-reset");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async out_valid", 32'(bus16.out_valid), 32'd0);
        chk("async in_ready", 32'(bus16.in_ready), 32'd1);
        chk("async out_ctrl", 32'(bus16.out_ctrl), 32'd0);
        chk("async out_data", bus16.out_data, 32'd0);
        chk("async stall16", 32'(stall16), 32'd0);
        chk("async stall4", 32'(stall4), 32'd0);
        mq.delete();
        mcnt = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // Accept on the first edge after release.
        cycle(1, 32'h42, 16'h0042, 1, 0);
        chk("first accept", bus16.out_data, 32'h42);
        check_model("first");
        cycle(0, 32'h0, 16'h0, 1, 0);

        // Counter saturation on the 4-bit instance; flush leaves it alone.
        cycle(1, 32'h99, 16'h1234, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 32'h0, 16'h0, 0, 0);
        chk("sat stall4", 32'(stall4), 32'd15);
        chk("sat stall16", 32'(stall16), 32'd20);
        cycle(0, 32'h0, 16'h0, 0, 1);
        chk("sat after flush", 32'(stall4), 32'd15);
        check_model("sat");

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
